// File: rtl/hilo_mul_seq.sv
// rtl/hilo_mul_seq.sv - HI/LO owner and multi-cycle MULT/MULTU sequencer for the shared ALU
// Optional: define HILO_MUL_CNT_EN to add the mul_count capture counter output.
module hilo_mul_seq #(
    parameter int         WIDTH       = 32,
    parameter int         MUL_LAT     = 1,
    parameter logic [4:0] OPSEL_IDLE  = 5'd0,
    parameter logic [4:0] OPSEL_MULT  = 5'd2,
    parameter logic [4:0] OPSEL_MULTU = 5'd3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_funct,
    input  logic [WIDTH-1:0] req_rs,
    input  logic [WIDTH-1:0] req_rt,
    output logic [4:0]       alu_opsel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_result_hi,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic             illegal
`ifdef HILO_MUL_CNT_EN
    ,
    output logic [31:0]      mul_count
`endif
);

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [3:0] CNT_INIT    = 4'(MUL_LAT - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q;
    logic [4:0] opsel_q;
    logic       accept;
    logic       is_mul;
    logic       capture;

    assign accept  = req_valid && req_ready;
    assign is_mul  = (req_funct == FUNCT_MULT) || (req_funct == FUNCT_MULTU);
    assign capture = (state_q == MUL) && (cnt_q == 4'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        busy      = 1'b0;
        alu_opsel = OPSEL_IDLE;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (accept && is_mul) begin
                    state_d = MUL;
                end
            end
            MUL: begin
                busy      = 1'b1;
                alu_opsel = opsel_q;
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // MT* lands at its own accept edge, so a following MF* sees the new value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= 4'd0;
            opsel_q   <= OPSEL_IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            hi        <= '0;
            lo        <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            illegal   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            illegal   <= 1'b0;
            if (state_q == MUL && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                hi <= alu_result_hi;
                lo <= alu_result;
            end
            if (accept) begin
                case (req_funct)
                    FUNCT_MULT, FUNCT_MULTU: begin
                        alu_a   <= req_rs;
                        alu_b   <= req_rt;
                        opsel_q <= (req_funct == FUNCT_MULT) ? OPSEL_MULT : OPSEL_MULTU;
                        cnt_q   <= CNT_INIT;
                    end
                    FUNCT_MTHI: hi <= req_rs;
                    FUNCT_MTLO: lo <= req_rs;
                    FUNCT_MFHI: begin
                        rsp_data  <= hi;
                        rsp_valid <= 1'b1;
                    end
                    FUNCT_MFLO: begin
                        rsp_data  <= lo;
                        rsp_valid <= 1'b1;
                    end
                    default: illegal <= 1'b1;
                endcase
            end
        end
    end

`ifdef HILO_MUL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mul_count <= 32'd0;
        end else if (capture) begin
            mul_count <= mul_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hilo_mul_seq.sv
// tb/tb_hilo_mul_seq.sv - directed bench for hilo_mul_seq at MUL_LAT=1 and MUL_LAT=3
module tb_hilo_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req_valid;
    logic [5:0]  req_funct;
    logic [31:0] req_rs, req_rt;

    logic        valid1, ready1, rspv1, busy1, ill1;
    logic [4:0]  opsel1;
    logic [31:0] a1, b1, res1, reshi1, hi1, lo1, rspd1;
    logic        valid3, ready3, rspv3, busy3, ill3;
    logic [4:0]  opsel3;
    logic [31:0] a3, b3, res3, reshi3, hi3, lo3, rspd3;
    logic [63:0] p1, p3;
`ifdef HILO_MUL_CNT_EN
    logic [31:0] mc1, mc3;
`endif

    int n_pass = 0;
    int n_checks = 0;
    int n, nb, bad;

    always #5 clk = ~clk;

    assign valid1 = req_valid && !sel;
    assign valid3 = req_valid && sel;

    function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == 5'd2) return {{32{a[31]}}, a} * {{32{b[31]}}, b};
        if (op == 5'd3) return {32'd0, a} * {32'd0, b};
        return 64'd0;
    endfunction

    assign p1 = alu_model(opsel1, a1, b1);
    assign p3 = alu_model(opsel3, a3, b3);
    assign {reshi1, res1} = p1;
    assign {reshi3, res3} = p3;

    hilo_mul_seq #(.WIDTH(32), .MUL_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_ready(ready1),
        .req_funct(req_funct), .req_rs(req_rs), .req_rt(req_rt),
        .alu_opsel(opsel1), .alu_a(a1), .alu_b(b1),
        .alu_result(res1), .alu_result_hi(reshi1), .hi(hi1), .lo(lo1),
        .rsp_valid(rspv1), .rsp_data(rspd1), .busy(busy1), .illegal(ill1)
`ifdef HILO_MUL_CNT_EN
        , .mul_count(mc1)
`endif
    );

    hilo_mul_seq #(.WIDTH(32), .MUL_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_ready(ready3),
        .req_funct(req_funct), .req_rs(req_rs), .req_rt(req_rt),
        .alu_opsel(opsel3), .alu_a(a3), .alu_b(b3),
        .alu_result(res3), .alu_result_hi(reshi3), .hi(hi3), .lo(lo3),
        .rsp_valid(rspv3), .rsp_data(rspd3), .busy(busy3), .illegal(ill3)
`ifdef HILO_MUL_CNT_EN
        , .mul_count(mc3)
`endif
    );

    // Observed view of whichever instance is selected
    wire        ready = sel ? ready3 : ready1;
    wire        busy  = sel ? busy3  : busy1;
    wire        rspv  = sel ? rspv3  : rspv1;
    wire        ill   = sel ? ill3   : ill1;
    wire [4:0]  opsel = sel ? opsel3 : opsel1;
    wire [31:0] a     = sel ? a3     : a1;
    wire [31:0] b     = sel ? b3     : b1;
    wire [31:0] hi    = sel ? hi3    : hi1;
    wire [31:0] lo    = sel ? lo3    : lo1;
    wire [31:0] rspd  = sel ? rspd3  : rspd1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt);
        req_funct = f;
        req_rs    = rs;
        req_rt    = rt;
        req_valid = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; req_valid = 1'b0;
        req_funct = 6'h0; req_rs = '0; req_rt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_hi", hi, 0);
            check("rst_lo", lo, 0);
            check("rst_ready", ready, 1);
            check("rst_busy", busy, 0);
            check("rst_opsel", opsel, 0);
            check("rst_rspv", rspv, 0);
            check("rst_ill", ill, 0);
        end
        rst_n = 1'b1;

        // MULT -3*5 at latency 1
        sel = 1'b0;
        req(6'h18, 32'hFFFFFFFD, 32'd5);
        tick();
        check("m1_busy", busy, 1);
        check("m1_ready", ready, 0);
        check("m1_opsel", opsel, 2);
        check("m1_a", a, 64'hFFFFFFFD);
        check("m1_b", b, 5);
        req_valid = 1'b0;
        tick();
        check("m1_busy_done", busy, 0);
        check("m1_ready_done", ready, 1);
        check("m1_opsel_idle", opsel, 0);
        check("m1_hi", hi, 64'hFFFFFFFF);
        check("m1_lo", lo, 64'hFFFFFFF1);
        check("m1_a_held", a, 64'hFFFFFFFD);
`ifdef HILO_MUL_CNT_EN
        check("m1_count", mc1, 1);
`endif

        // MTHI then back-to-back MFHI, MFLO at latency 3
        sel = 1'b1;
        req(6'h11, 32'h00001234, 32'd0);
        tick();
        check("mthi_hi", hi, 64'h1234);
        check("mthi_lo", lo, 0);
        check("mthi_rspv", rspv, 0);
        req_funct = 6'h10;
        tick();
        check("mfhi_rspv", rspv, 1);
        check("mfhi_data", rspd, 64'h1234);
        req_funct = 6'h12;
        tick();
        check("mflo_rspv", rspv, 1);
        check("mflo_data", rspd, 0);
        req_valid = 1'b0;
        tick();
        check("mflo_pulse_end", rspv, 0);

        // MULTU 0xFFFFFFFF*2 at latency 3
        req(6'h19, 32'hFFFFFFFF, 32'd2);
        tick();
        req_valid = 1'b0;
        n = 0; nb = 0;
        while (!ready && n < 20) begin
            n++;
            nb += int'(busy);
            if (opsel != 5'd3) check("mu_opsel", opsel, 3);
            tick();
        end
        check("mu_ready_low", n, 3);
        check("mu_busy_cycles", nb, 3);
        check("mu_hi", hi, 1);
        check("mu_lo", lo, 64'hFFFFFFFE);

        // MULT 7*6 with MFLO held valid through the stall
        req(6'h18, 32'd7, 32'd6);
        tick();
        req_funct = 6'h12;
        n = 0; bad = 0;
        while (!ready && n < 20) begin
            n++;
            if (rspv) bad++;
            tick();
        end
        check("m76_stall", n, 3);
        check("m76_no_early_rsp", bad, 0);
        tick();
        check("m76_rspv", rspv, 1);
        check("m76_data", rspd, 64'h2A);
        req_valid = 1'b0;
        tick();

        // Reset during the second busy cycle aborts
        req(6'h19, 32'd3, 32'd4);
        tick();
        req_valid = 1'b0;
        tick();
        check("abort_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        check("abort_ready", ready, 1);
        check("abort_busy_clr", busy, 0);
        check("abort_opsel", opsel, 0);
`ifdef HILO_MUL_CNT_EN
        check("abort_count", mc3, 0);
`endif

        // Illegal funct leaves state alone
        req(6'h13, 32'h000055AA, 32'd0);
        tick();
        req(6'h20, 32'h0000DEAD, 32'h0000BEEF);
        tick();
        check("ill_pulse", ill, 1);
        check("ill_hi", hi, 0);
        check("ill_lo", lo, 64'h55AA);
        check("ill_ready", ready, 1);
        req_funct = 6'h12;
        tick();
        check("ill_pulse_end", ill, 0);
        check("ill_mflo_rspv", rspv, 1);
        check("ill_mflo_data", rspd, 64'h55AA);
        req_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
